password_show_ctrl: RTL

//   Parametrised password-reveal controller for the bomb-dismantlement game. On a start pulse it

---
 rtl/pw_show_pkg.sv | 34 +++
 rtl/seg7_scan.sv | 72 +++++++
 rtl/password_show_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pw_show_pkg.sv
// Shared types, display constants and the 7-segment font for the password-reveal controller.
package pw_show_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] CAT_OFF   = 8'hFF;
  localparam logic [7:0] CAT_ONES  = 8'hFE;
  localparam logic [7:0] CAT_TENS  = 8'hFD;

  // Active-high segments {dp,g,f,e,d,c,b,a}; anything above 9 is dark.
  function automatic logic [7:0] seg7_font(input logic [3:0] digit);
    logic [7:0] pat;
    case (digit)
      4'd0: pat = 8'h3F;
      4'd1: pat = 8'h06;
      4'd2: pat = 8'h5B;
      4'd3: pat = 8'h4F;
      4'd4: pat = 8'h66;
      4'd5: pat = 8'h6D;
      4'd6: pat = 8'h7D;
      4'd7: pat = 8'h07;
      4'd8: pat = 8'h7F;
      4'd9: pat = 8'h6F;
      default: pat = 8'h00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Two-digit multiplexed 7-segment driver: binary 0..99 to BCD, slot scan, leading-zero blanking.
// Inputs describe the next cycle, so seg/cat are registered yet valid on the first active cycle.
module seg7_scan
  import pw_show_pkg::*;
#(
  parameter int SCAN_DIV = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic       blank,
  input  logic [6:0] value,
  output logic [7:0] seg,
  output logic [7:0] cat
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] scan_cnt;
  logic [SW-1:0] scan_cnt_n;
  logic          slot;
  logic          slot_n;
  logic          active;
  logic [3:0]    tens;
  logic [3:0]    ones;

  assign tens = 4'(value / 7'd10);
  assign ones = 4'(value % 7'd10);

  // A fresh activation always starts on the ones slot with an empty scan counter.
  always_comb begin
    scan_cnt_n = '0;
    slot_n     = 1'b0;
    if (on && active) begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt_n = '0;
        slot_n     = ~slot;
      end else begin
        scan_cnt_n = scan_cnt + SW'(1);
        slot_n     = slot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      slot     <= 1'b0;
      active   <= 1'b0;
      seg      <= SEG_BLANK;
      cat      <= CAT_OFF;
    end else begin
      active   <= on;
      scan_cnt <= scan_cnt_n;
      slot     <= slot_n;
      if (!on) begin
        seg <= SEG_BLANK;
        cat <= CAT_OFF;
      end else if (!slot_n) begin
        cat <= CAT_ONES;
        seg <= blank ? SEG_BLANK : seg7_font(ones);
      end else if (tens == 4'd0) begin
        cat <= CAT_OFF;
        seg <= SEG_BLANK;
      end else begin
        cat <= CAT_TENS;
        seg <= blank ? SEG_BLANK : seg7_font(tens);
      end
    end
  end

endmodule

// File: rtl/password_show_ctrl.sv
// Password-reveal controller: latches psw on the LEDs and counts SHOW_SECS ticks down on two digits.
// Define SHOW_BLINK_EN to blink LEDs and segments during the final tick.
module password_show_ctrl
  import pw_show_pkg::*;
#(
  parameter int PSW_W     = 7,
  parameter int SHOW_SECS = 5,
  parameter int TICK_DIV  = 1000,
  parameter int SCAN_DIV  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PSW_W-1:0] psw,
  output logic [PSW_W-1:0] LD,
  output logic [7:0]       seg,
  output logic [7:0]       cat,
  output logic             busy,
  output logic             end_of_show
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(SHOW_SECS + 1);

  state_t           state;
  logic [TW-1:0]    tick_cnt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic [PSW_W-1:0] psw_q;
  logic             tick;
  logic             enter;
  logic             leave;
  logic             on_n;
  logic             vis_n;

  assign tick    = (state == SHOW) && (tick_cnt == TW'(TICK_DIV - 1));
  assign enter   = (state != SHOW) && start && !abort;
  assign leave   = (state == SHOW) && (abort || (tick && count == CW'(1)));
  assign on_n    = enter || ((state == SHOW) && !leave);
  // Count holds at 1 on the final tick; leaving SHOW is what ends it.
  assign count_n = enter ? CW'(SHOW_SECS)
                 : (tick && count > CW'(1)) ? count - CW'(1)
                 : count;

`ifdef SHOW_BLINK_EN
  localparam int BQ = (TICK_DIV / 4 > 0) ? TICK_DIV / 4 : 1;
  localparam int BW = (BQ > 1) ? $clog2(BQ) : 1;

  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_n;
  logic          blink_vis;
  logic          blink_restart;

  // Phase restarts visible whenever the final tick begins.
  assign blink_restart = enter || (tick && count == CW'(2));

  always_comb begin
    blink_cnt_n = '0;
    vis_n       = 1'b1;
    if (!blink_restart && state == SHOW && count == CW'(1)) begin
      if (blink_cnt == BW'(BQ - 1)) begin
        blink_cnt_n = '0;
        vis_n       = ~blink_vis;
      end else begin
        blink_cnt_n = blink_cnt + BW'(1);
        vis_n       = blink_vis;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else begin
      blink_cnt <= blink_cnt_n;
      blink_vis <= vis_n;
    end
  end
`else
  assign vis_n = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (enter) psw_q <= psw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      count       <= '0;
      LD          <= '0;
      busy        <= 1'b0;
      end_of_show <= 1'b0;
    end else begin
      count <= count_n;
      case (state)
        IDLE, DONE: begin
          if (abort) begin
            state       <= IDLE;
            end_of_show <= 1'b0;
          end else if (start) begin
            state       <= SHOW;
            tick_cnt    <= '0;
            LD          <= psw;
            busy        <= 1'b1;
            end_of_show <= 1'b0;
          end
        end
        SHOW: begin
          if (abort) begin
            state    <= IDLE;
            tick_cnt <= '0;
            LD       <= '0;
            busy     <= 1'b0;
          end else if (tick && count == CW'(1)) begin
            state       <= DONE;
            tick_cnt    <= '0;
            LD          <= '0;
            busy        <= 1'b0;
            end_of_show <= 1'b1;
          end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            LD       <= vis_n ? psw_q : '0;
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          LD       <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .on   (on_n),
    .blank(!vis_n),
    .value(7'(count_n)),
    .seg  (seg),
    .cat  (cat)
  );

endmodule
